// File: rtl/bringup_pkg.sv
// Shared definitions for the board bring-up sequencer: FSM state codes and
// the widths of the state and retry-count outputs.
package bringup_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StWaitPll = 3'd0,
    StHold    = 3'd1,
    StWaitDdr = 3'd2,
    StRun     = 3'd3,
    StFault   = 3'd4
  } state_e;

endpackage

// File: rtl/lane_rst_ctrl.sv
// Per-lane reset controller: follows lane_enable while released, and in RUN
// re-holds the lane reset for RST_HOLD cycles on link loss or new enable.
module lane_rst_ctrl #(
  parameter int unsigned RST_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic do_release,
  input  logic enable,
  input  logic up,
  output logic lane_rst_n
);

  localparam int unsigned CntW = $clog2(RST_HOLD + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(RST_HOLD - 1);
  localparam logic [CntW-1:0] HoldMax  = CntW'(RST_HOLD);

  logic            rst_n_q, rst_n_d;
  logic            up_q, en_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    rst_n_d = rst_n_q;
    cnt_d   = '0;
    if (do_release) begin
      rst_n_d = enable;
    end else if (!run || !enable) begin
      rst_n_d = 1'b0;
    end else if (!en_q) begin
      rst_n_d = 1'b0;
    end else if (!rst_n_q) begin
      // Hold in progress: link events are ignored until it expires
      if (cnt_q >= HoldLast) begin
        rst_n_d = 1'b1;
      end else begin
        cnt_d = (cnt_q == HoldMax) ? cnt_q : cnt_q + 1'b1;
      end
    end else if (up_q && !up) begin
      rst_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q <= 1'b0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      rst_n_q <= rst_n_d;
      cnt_q   <= cnt_d;
      up_q    <= up;
      en_q    <= enable;
    end
  end

  assign lane_rst_n = rst_n_q;

endmodule

// File: rtl/bringup_seq.sv
// Board bring-up sequencer: PLL lock filter, DDR reset/calibration wait and
// per-lane reset control. Define BRINGUP_RETRY_EN to retry DDR bring-up.
module bringup_seq
  import bringup_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned NUM_DDR     = 2,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned DDR_TIMEOUT = 1048576,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic [NUM_DDR-1:0]   ddr_cal_success,
  input  logic [NUM_DDR-1:0]   ddr_cal_fail,
  input  logic [NUM_LANES-1:0] lane_enable,
  input  logic [NUM_LANES-1:0] lane_up,
  output logic [NUM_LANES-1:0] lane_rst_n,
  output logic                 ddr_rst_n,
  output logic                 ddr_ok,
  output logic                 ready,
  output logic                 fault,
  output logic [STATE_W-1:0]   state,
  output logic [RETRY_W-1:0]   retry_count
);

  localparam int unsigned LockW  = $clog2(LOCK_FILTER + 1);
  localparam int unsigned HoldW  = $clog2(RST_HOLD + 1);
  localparam int unsigned TimerW = $clog2(DDR_TIMEOUT + 1);

  localparam logic [LockW-1:0]  LockLast  = LockW'(LOCK_FILTER - 1);
  localparam logic [LockW-1:0]  LockMax   = LockW'(LOCK_FILTER);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(RST_HOLD - 1);
  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(RST_HOLD);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(DDR_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(DDR_TIMEOUT);

  logic               pll_meta_q, pll_sync_q, locked;
  state_e             state_q, state_d;
  logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               ddr_rst_n_q, ddr_rst_n_d;
  logic               ddr_ok_q, ddr_ok_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               ddr_all_ok, ddr_give_up;

  assign locked      = pll_sync_q;
  assign ddr_all_ok  = &ddr_cal_success;
  // Fail beats success, success beats timeout
  assign ddr_give_up = (|ddr_cal_fail) || (!ddr_all_ok && timer_q >= TimerLast);

`ifdef BRINGUP_RETRY_EN
  localparam logic [RETRY_W-1:0] RetryMax = RETRY_W'(MAX_RETRY);
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pll_meta_q  <= 1'b0;
      pll_sync_q  <= 1'b0;
      state_q     <= StWaitPll;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      ddr_rst_n_q <= 1'b0;
      ddr_ok_q    <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pll_meta_q  <= pll_locked;
      pll_sync_q  <= pll_meta_q;
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      ddr_rst_n_q <= ddr_rst_n_d;
      ddr_ok_q    <= ddr_ok_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      StWaitPll: if (locked && lock_cnt_q >= LockLast) state_d = StHold;
      StHold: begin
        if (!locked)                      state_d = StWaitPll;
        else if (hold_cnt_q >= HoldLast)  state_d = StWaitDdr;
      end
      StWaitDdr: begin
        if (!locked) begin
          state_d = StWaitPll;
        end else if (ddr_give_up) begin
`ifdef BRINGUP_RETRY_EN
          if (retry_q < RetryMax) begin
            state_d = StHold;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = StFault;
          end
`else
          state_d = StFault;
`endif
        end else if (ddr_all_ok) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!locked)          state_d = StWaitPll;
        else if (!ddr_all_ok) state_d = StFault;
      end
      StFault: state_d = StFault;
      default: state_d = StWaitPll;
    endcase

    lock_cnt_d = '0;
    if (state_q == StWaitPll && locked) begin
      lock_cnt_d = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end
    hold_cnt_d = '0;
    if (state_q == StHold && state_d == StHold) begin
      hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
    timer_d = '0;
    if (state_q == StWaitDdr && state_d == StWaitDdr) begin
      timer_d = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    ddr_rst_n_d = ddr_rst_n_q;
    case (state_d)
      StWaitPll, StHold: ddr_rst_n_d = 1'b0;
      StWaitDdr, StRun:  ddr_rst_n_d = 1'b1;
      default:           ddr_rst_n_d = ddr_rst_n_q;
    endcase
    ddr_ok_d = (state_d == StRun);
    ready_d  = (state_d == StRun);
    fault_d  = (state_d == StFault);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_rst_ctrl #(
      .RST_HOLD(RST_HOLD)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (state_d == StRun),
      .do_release(state_d == StWaitDdr),
      .enable    (lane_enable[i]),
      .up        (lane_up[i]),
      .lane_rst_n(lane_rst_n[i])
    );
  end

  assign ddr_rst_n   = ddr_rst_n_q;
  assign ddr_ok      = ddr_ok_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign state       = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_bringup_seq.sv
// Directed bench for bringup_seq with LOCK_FILTER=4, RST_HOLD=8, DDR_TIMEOUT=64;
// follows the DUT build for BRINGUP_RETRY_EN.
module tb_bringup_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [1:0] ddr_cal_success, ddr_cal_fail;
  logic [3:0] lane_enable, lane_up;
  logic [3:0] lane_rst_n;
  logic       ddr_rst_n, ddr_ok, ready, fault;
  logic [2:0] state;
  logic [1:0] retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bringup_seq #(
    .NUM_LANES  (4),
    .NUM_DDR    (2),
    .LOCK_FILTER(4),
    .RST_HOLD   (8),
    .DDR_TIMEOUT(64),
    .MAX_RETRY  (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .ddr_cal_success(ddr_cal_success),
    .ddr_cal_fail   (ddr_cal_fail),
    .lane_enable    (lane_enable),
    .lane_up        (lane_up),
    .lane_rst_n     (lane_rst_n),
    .ddr_rst_n      (ddr_rst_n),
    .ddr_ok         (ddr_ok),
    .ready          (ready),
    .fault          (fault),
    .state          (state),
    .retry_count    (retry_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample 1ns after the n-th rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int st, input int lanes, input int drst,
                           input int ok, input int rdy, input int flt, input int rc);
    check_eq({tag, ".state"}, 32'(state), st);
    check_eq({tag, ".lane_rst_n"}, 32'(lane_rst_n), lanes);
    check_eq({tag, ".ddr_rst_n"}, 32'(ddr_rst_n), drst);
    check_eq({tag, ".ddr_ok"}, 32'(ddr_ok), ok);
    check_eq({tag, ".ready"}, 32'(ready), rdy);
    check_eq({tag, ".fault"}, 32'(fault), flt);
    check_eq({tag, ".retry"}, 32'(retry_count), rc);
  endtask

  initial begin
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    ddr_cal_success = 2'b00;
    ddr_cal_fail    = 2'b00;
    lane_enable     = 4'b1011;
    lane_up         = 4'b1111;
    tick(2);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(1);

    // Bring-up: 2 sync + 4 filter cycles to HOLD, 8 hold cycles to WAIT_DDR
    pll_locked = 1'b1;
    tick(5);
    check_eq("lock.before", 32'(state), 0);
    tick(1);
    check_all("lock.hold", 1, 0, 0, 0, 0, 0, 0);
    tick(7);
    check_all("hold.end", 1, 0, 0, 0, 0, 0, 0);
    tick(1);
    check_all("wait_ddr", 2, 'hB, 1, 0, 0, 0, 0);
    tick(9);
    check_eq("wait_ddr.still", 32'(state), 2);
    ddr_cal_success = 2'b11;
    tick(1);
    check_all("run", 3, 'hB, 1, 1, 1, 0, 0);

    // Lane 1 link loss: exactly 8 cycles of reset, a second fall mid-hold ignored
    lane_up[1] = 1'b0;
    tick(1);
    check_eq("lane1.fall", 32'(lane_rst_n), 'h9);
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) lane_up[1] = 1'b1;
      if (k == 3) lane_up[1] = 1'b0;
      tick(1);
      check_eq("lane1.hold", 32'(lane_rst_n), 'h9);
      check_eq("lane1.ready", 32'(ready), 1);
    end
    tick(1);
    check_eq("lane1.release", 32'(lane_rst_n), 'hB);
    lane_up[1] = 1'b1;

    // Lane 0 disable then re-enable
    lane_enable = 4'b1010;
    tick(1);
    check_eq("lane0.disable", 32'(lane_rst_n), 'hA);
    lane_enable = 4'b1011;
    tick(8);
    check_eq("lane0.reenable_hold", 32'(lane_rst_n), 'hA);
    tick(1);
    check_eq("lane0.reenable_rel", 32'(lane_rst_n), 'hB);

    // PLL loss in RUN: seen after the 2-flop synchroniser
    pll_locked = 1'b0;
    tick(2);
    check_eq("pll_loss.sync", 32'(state), 3);
    tick(1);
    check_all("pll_loss", 0, 0, 0, 0, 0, 0, 0);
    ddr_cal_success = 2'b00;

    // Relock, then calibration never completes
    pll_locked = 1'b1;
    tick(6);
    check_eq("relock.hold", 32'(state), 1);
    tick(8);
    check_all("relock.wait_ddr", 2, 'hB, 1, 0, 0, 0, 0);
    tick(63);
    check_eq("timeout.t63", 32'(state), 2);
    tick(1);
`ifdef BRINGUP_RETRY_EN
    check_all("retry1", 1, 0, 0, 0, 0, 0, 1);
    for (int r = 2; r <= 3; r++) begin
      tick(8);
      check_eq("retry.wait_ddr", 32'(state), 2);
      tick(64);
      check_all("retry.hold", 1, 0, 0, 0, 0, 0, r);
    end
    tick(8);
    check_eq("retry.last_wait", 32'(state), 2);
    tick(64);
    check_all("retry.fault", 4, 0, 1, 0, 0, 1, 3);
`else
    check_all("timeout.fault", 4, 0, 1, 0, 0, 1, 0);
`endif
    tick(3);
    check_eq("fault.sticky", 32'(fault), 1);

    // Reset mid-operation
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick(1);
    check_all("rst.mid", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Lock glitch after 3 high cycles restarts the filter
    pll_locked = 1'b1;
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    check_eq("glitch.e6", 32'(state), 0);
    tick(3);
    check_eq("glitch.e9", 32'(state), 0);
    tick(1);
    check_eq("glitch.hold", 32'(state), 1);
    tick(8);
    check_eq("glitch.wait_ddr", 32'(state), 2);

    // Success and fail together: fail wins
    ddr_cal_success = 2'b11;
    ddr_cal_fail    = 2'b01;
    tick(1);
`ifdef BRINGUP_RETRY_EN
    check_all("fail_wins", 1, 0, 0, 0, 0, 0, 1);
`else
    check_all("fail_wins", 4, 0, 1, 0, 0, 1, 0);
`endif

    ddr_cal_success = 2'b00;
    ddr_cal_fail    = 2'b00;
    rst_n           = 1'b0;
    tick(1);
    check_all("rst.final", 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
